sync_data_fifo: RTL and testbench

- Single-clock synchronous FIFO used as the spike/config flit queue between the flit producer (`data_Recv`) and the flit sender (`flit_send`).
- Built from two parts:
  - a dual-port storage RAM submodule, `fifo_ram`: one write port, one synchronous read port, registered read data;
  - FIFO control: pointers, occupancy count, empty and almost_full flags.
- Read data arrives one cycle after the pop request.

---
 rtl/sync_data_fifo.sv | 146 ++++++++++++++
 tb/tb_sync_data_fifo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sync_data_fifo.sv
// sync_data_fifo: single-clock flit queue between data_Recv and flit_send.
//
// Contains:
//   - fifo_ram: dual-port storage with a registered synchronous read port.
//     It has no FIFO knowledge, so it can also be used as a plain lookup RAM.
//   - sync_data_fifo: pointers, occupancy count, and the empty/almost_full flags.
//
// Pop data appears on dout one cycle after an accepted rd_en.
// dout holds its value when no pop is accepted.
//
// Optional build macro: DATA_FIFO_CHECK_EN
//   When defined, simulation-only overflow/underflow messages are compiled in.
//   Functional behaviour is the same with or without it.

module fifo_ram #(
    parameter int DATA_WIDTH = 59,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Next read register value: new word on a read, otherwise hold.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Storage write and read register.
    // A read and a write to the same address on one edge return the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

module sync_data_fifo #(
    parameter int DATA_WIDTH = 59,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  almost_full,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_AF   = {1'b0, {ADDR_WIDTH{1'b1}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_d,  count_q;
    logic                  full;
    logic                  push_ok;
    logic                  pop_ok;

    assign full        = (count_q == CNT_FULL);
    assign empty       = (count_q == '0);
    // Asserts one entry early, so a producer that reacts a cycle late still fits.
    assign almost_full = (count_q >= CNT_AF);

    assign push_ok = wr_en & ~full;
    assign pop_ok  = rd_en & ~empty;

    // Next pointer and occupancy values from the accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (ADDR_WIDTH+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (ADDR_WIDTH+1)'(1);
        end
    end

    // Control state; reset discards contents and raises empty immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push_ok),
        .rd_en   (pop_ok),
        .wr_data (din),
        .wr_addr (wr_ptr_q),
        .rd_addr (rd_ptr_q),
        .rd_data (dout)
    );

`ifdef DATA_FIFO_CHECK_EN
    // Simulation-only reporting of dropped pushes and ignored pops.
    always @(posedge clk) begin
        if (rst_n) begin
            if (wr_en && full) begin
                $display("ERROR: FIFO overflow at time %0t in %m", $time);
            end
            if (rd_en && empty) begin
                $display("ERROR: FIFO underflow at time %0t in %m", $time);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_sync_data_fifo.sv
// Directed bench for sync_data_fifo and a standalone fifo_ram instance.
module tb_sync_data_fifo;

    localparam int DW = 59;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          almost_full;
    logic          empty;

    logic          r_we, r_re;
    logic [15:0]   r_wd, r_rd;
    logic [3:0]    r_wa, r_ra;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_data_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .din         (din),
        .dout        (dout),
        .almost_full (almost_full),
        .empty       (empty)
    );

    fifo_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) u_ram_alone (
        .clk     (clk),
        .wr_en   (r_we),
        .rd_en   (r_re),
        .wr_data (r_wd),
        .wr_addr (r_wa),
        .rd_addr (r_ra),
        .rd_data (r_rd)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        wr_en = 1'b1;
        din   = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        r_we = 1'b0; r_re = 1'b0; r_wd = '0; r_wa = '0; r_ra = '0;
        #12;
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_af", 64'(almost_full), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Underflow from reset
        rd_en = 1'b1;
        tick(); tick(); tick();
        rd_en = 1'b0;
        chk("uflow_empty", 64'(empty), 64'd1);
        chk("uflow_rdptr", 64'(dut.rd_ptr_q), 64'd0);
        chk("uflow_wrptr", 64'(dut.wr_ptr_q), 64'd0);

        // Basic ordering
        push(59'h1); push(59'h2); push(59'h3);
        chk("basic_not_empty", 64'(empty), 64'd0);
        pop(); chk("basic_pop1", 64'(dout), 64'h1);
        pop(); chk("basic_pop2", 64'(dout), 64'h2);
        pop(); chk("basic_pop3", 64'(dout), 64'h3);
        chk("basic_empty", 64'(empty), 64'd1);

        // Fill, almost_full, overflow
        for (int i = 0; i < 14; i++) push(59'(i + 16'h10));
        chk("fill14_af", 64'(almost_full), 64'd0);
        push(59'h1E);
        chk("fill15_af", 64'(almost_full), 64'd1);
        push(59'h1F);
        chk("fill16_count", 64'(dut.count_q), 64'd16);
        push(59'hAA);
        chk("ovf_count", 64'(dut.count_q), 64'd16);
        for (int i = 0; i < 16; i++) begin
            pop();
            chk($sformatf("drain_%0d", i), 64'(dout), 64'(i + 16'h10));
            if (i == 1) chk("drain_af_low", 64'(almost_full), 64'd0);
        end
        chk("drain_empty", 64'(empty), 64'd1);
        pop();
        chk("drain_no_aa", 64'(dout), 64'h1F);

        // Steady state at 8 entries across pointer wrap
        for (int i = 0; i < 8; i++) push(59'(i + 16'h100));
        for (int k = 0; k < 20; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; din = 59'(k + 16'h108);
            tick();
            chk($sformatf("stream_dout_%0d", k), 64'(dout), 64'(k + 16'h100));
            chk($sformatf("stream_cnt_%0d", k), 64'(dut.count_q), 64'd8);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pop();
            chk($sformatf("stream_tail_%0d", i), 64'(dout), 64'(i + 16'h114));
        end
        chk("stream_empty", 64'(empty), 64'd1);

        // Simultaneous push/pop while empty
        wr_en = 1'b1; rd_en = 1'b1; din = 59'h5A;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("empty_both_dout", 64'(dout), 64'h11B);
        chk("empty_both_flag", 64'(empty), 64'd0);
        pop();
        chk("empty_both_pop", 64'(dout), 64'h5A);
        chk("empty_both_after", 64'(empty), 64'd1);

        // Simultaneous push/pop while full: only the pop happens
        for (int i = 0; i < 16; i++) push(59'(i + 16'h200));
        wr_en = 1'b1; rd_en = 1'b1; din = 59'hBB;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("full_both_dout", 64'(dout), 64'h200);
        chk("full_both_count", 64'(dut.count_q), 64'd15);
        for (int i = 1; i < 16; i++) begin
            pop();
            chk($sformatf("full_drain_%0d", i), 64'(dout), 64'(i + 16'h200));
        end
        chk("full_drain_empty", 64'(empty), 64'd1);

        // Asynchronous reset mid-operation
        push(59'h77); push(59'h78);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_empty", 64'(empty), 64'd1);
        chk("async_rst_count", 64'(dut.count_q), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Standalone RAM
        r_we = 1'b1; r_wa = 4'd3; r_wd = 16'h1234;
        tick();
        r_we = 1'b0; r_re = 1'b1; r_ra = 4'd3;
        tick();
        chk("ram_read", 64'(r_rd), 64'h1234);
        r_we = 1'b1; r_wd = 16'h5678;
        tick();
        r_we = 1'b0;
        chk("ram_rw_old", 64'(r_rd), 64'h1234);
        tick();
        chk("ram_read_new", 64'(r_rd), 64'h5678);
        r_re = 1'b0; r_ra = 4'd0;
        tick(); tick();
        chk("ram_hold", 64'(r_rd), 64'h5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
